fir_mac_engine: RTL and testbench

- Downstream consumer of the dual-channel sample FIFO.
- Pops one sample pair (channel 1 and channel 2) whenever the FIFO is non-empty and shifts each sample into its own NTAPS-deep delay line.
- Computes both FIR outputs with one shared, time-multiplexed MAC pass over a loadable coefficient bank.
- Presents the rounded, saturated results on a valid/ready output port.

---
 rtl/fir_mac_engine.sv | 129 ++++++++++++
 tb/tb_fir_mac_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - dual-channel FIR with one shared, time-multiplexed MAC
module fir_mac_engine #(
  parameter int DWIDTH = 24,
  parameter int CWIDTH = 16,
  parameter int NTAPS  = 8,
  parameter int TAW    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd,
  input  logic signed [DWIDTH-1:0] fifo_data1,
  input  logic signed [DWIDTH-1:0] fifo_data2,
  input  logic                     coef_wr,
  input  logic [TAW-1:0]           coef_addr,
  input  logic signed [CWIDTH-1:0] coef_data,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] out_data1,
  output logic signed [DWIDTH-1:0] out_data2
);

  localparam int PW = DWIDTH + CWIDTH;
  localparam int AW = DWIDTH + CWIDTH + TAW;
  localparam logic signed [AW-1:0] HALF = AW'(1) << (CWIDTH - 3);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
  localparam logic signed [CWIDTH-1:0] UNITY = CWIDTH'(1) << (CWIDTH - 2);

  typedef enum logic [1:0] {IDLE, MAC, RND, OUT} state_t;

  state_t                    state, state_nxt;
  logic signed [DWIDTH-1:0]  x1 [NTAPS];
  logic signed [DWIDTH-1:0]  x2 [NTAPS];
  logic signed [CWIDTH-1:0]  coef [NTAPS];
  logic [TAW-1:0]            k;
  logic signed [AW-1:0]      acc1, acc2;
  // A write landing on the pop edge is kept out of that sample by remembering the
  // coefficient it replaced and substituting it while this sample is computed.
  logic                      save_vld;
  logic [TAW-1:0]            save_addr;
  logic signed [CWIDTH-1:0]  save_data;
  logic signed [CWIDTH-1:0]  c_k;
  logic signed [PW-1:0]      prod1, prod2;

  function automatic logic signed [DWIDTH-1:0] rnd_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = (a + HALF) >>> (CWIDTH - 2);
    if (s > MAXV)      return MAXV[DWIDTH-1:0];
    else if (s < MINV) return MINV[DWIDTH-1:0];
    else               return s[DWIDTH-1:0];
  endfunction

  assign fifo_rd = (state == IDLE) && !fifo_empty && rst;
  assign busy    = (state != IDLE);
  assign c_k     = (save_vld && (save_addr == k)) ? save_data : coef[k];
  assign prod1   = PW'(x1[k]) * PW'(c_k);
  assign prod2   = PW'(x2[k]) * PW'(c_k);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode: pop, NTAPS MAC cycles, round, hold until accepted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fifo_rd) state_nxt = MAC;
      MAC:  if (k == TAW'(NTAPS - 1)) state_nxt = RND;
      RND:  state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: delay lines, coefficient bank, accumulators and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        x1[i]   <= '0;
        x2[i]   <= '0;
        coef[i] <= (i == 0) ? UNITY : '0;
      end
      k         <= '0;
      acc1      <= '0;
      acc2      <= '0;
      save_vld  <= 1'b0;
      save_addr <= '0;
      save_data <= '0;
      out_valid <= 1'b0;
      out_data1 <= '0;
      out_data2 <= '0;
    end else begin
      if ((state == IDLE) && coef_wr) coef[coef_addr] <= coef_data;
      case (state)
        IDLE: if (fifo_rd) begin
          x1[0] <= fifo_data1;
          x2[0] <= fifo_data2;
          for (int i = 1; i < NTAPS; i++) begin
            x1[i] <= x1[i-1];
            x2[i] <= x2[i-1];
          end
          acc1      <= '0;
          acc2      <= '0;
          k         <= '0;
          save_vld  <= coef_wr;
          save_addr <= coef_addr;
          save_data <= coef[coef_addr];
        end
        MAC: begin
          acc1 <= acc1 + AW'(prod1);
          acc2 <= acc2 + AW'(prod2);
          k    <= k + 1'b1;
        end
        RND: begin
          out_data1 <= rnd_sat(acc1);
          out_data2 <= rnd_sat(acc2);
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - directed self-checking bench for fir_mac_engine
module tb_fir_mac_engine;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               fifo_empty = 1'b1;
  logic               fifo_rd;
  logic signed [23:0] fifo_data1 = '0;
  logic signed [23:0] fifo_data2 = '0;
  logic               coef_wr = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [15:0] coef_data = '0;
  logic               busy;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [23:0] out_data1;
  logic signed [23:0] out_data2;

  fir_mac_engine dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_data1(fifo_data1), .fifo_data2(fifo_data2),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2)
  );

  always #5 clk = ~clk;

  int      n_cmp = 0;
  int      n_bad = 0;
  int      cyc = 0;
  int      pops = 0;
  logic    last_rd, last_hs, last_ov;
  longint  fq1[$], fq2[$], oq1[$], oq2[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty = (fq1.size() == 0);
    fifo_data1 = fifo_empty ? 24'sd0 : 24'(fq1[0]);
    fifo_data2 = fifo_empty ? 24'sd0 : 24'(fq2[0]);
  endtask

  task automatic push(input longint a, input longint b);
    fq1.push_back(a);
    fq2.push_back(b);
    fifo_refresh();
  endtask

  // One clock: sample at negedge, let the edge happen, update the FIFO model after it
  task automatic tick();
    @(negedge clk);
    last_rd = fifo_rd;
    last_ov = out_valid;
    last_hs = out_valid & out_ready;
    if (last_hs) begin
      oq1.push_back(longint'(out_data1));
      oq2.push_back(longint'(out_data2));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (last_rd && fq1.size() > 0) begin
      void'(fq1.pop_front());
      void'(fq2.pop_front());
      pops++;
      fifo_refresh();
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    fq1.delete(); fq2.delete(); oq1.delete(); oq2.delete();
    fifo_refresh();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic coef_write(input int addr, input longint val);
    coef_wr = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 16'(val);
    tick();
    coef_wr = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    int b;
    b = 0;
    while (oq1.size() < n && b < 400) begin
      tick();
      b++;
    end
    chk({tag, "_count"}, oq1.size(), n);
  endtask

  task automatic expect_out(input string tag, input longint e1, input longint e2);
    if (oq1.size() == 0) begin
      chk({tag, "_missing"}, 0, 1);
    end else begin
      chk({tag, "_ch1"}, oq1.pop_front(), e1);
      chk({tag, "_ch2"}, oq2.pop_front(), e2);
    end
  endtask

  task automatic wait_pop(input string tag);
    int b;
    b = 0;
    last_rd = 1'b0;
    while (!last_rd && b < 50) begin
      tick();
      b++;
    end
    chk({tag, "_pop_seen"}, last_rd, 1);
  endtask

  initial begin
    int t0, lat, b;

    // 1: reset defaults, latency, identity filter
    push(100, -100);
    repeat (3) tick();
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data1", out_data1, 0);
    chk("rst_out_data2", out_data2, 0);
    rst = 1'b1;
    pops = 0;
    t0 = -1;
    lat = -1;
    b = 0;
    while (lat < 0 && b < 60) begin
      tick();
      b++;
      if (last_rd && t0 < 0) t0 = cyc;
      if (last_ov && t0 >= 0) lat = cyc - t0 - 1;
    end
    chk("t1_latency", lat, 9);
    chk("t1_pops", pops, 1);
    drain("t1a", 1);
    expect_out("t1a", 100, -100);
    push(5, 7);
    drain("t1b", 1);
    expect_out("t1b", 5, 7);

    // 2: eight-tap moving average
    reset_dut();
    for (int i = 0; i < 8; i++) coef_write(i, 2048);
    for (int i = 0; i < 8; i++) push(800, -800);
    drain("t2", 8);
    for (int i = 1; i <= 8; i++) expect_out($sformatf("t2_%0d", i), 100 * i, -100 * i);

    // 3: saturation at both rails with gain -2.0
    reset_dut();
    coef_write(0, -32768);
    push(8388607, -8388608);
    push(1000, 0);
    drain("t3", 2);
    expect_out("t3_sat", -8388608, 8388607);
    expect_out("t3_lin", -2000, 0);

    // 4: round-half-up with gain 0.5
    reset_dut();
    coef_write(0, 8192);
    push(3, 3); push(-3, -3); push(1, 1); push(-1, -1);
    drain("t4", 4);
    expect_out("t4_p3", 2, 2);
    expect_out("t4_m3", -1, -1);
    expect_out("t4_p1", 1, 1);
    expect_out("t4_m1", 0, 0);

    // 5: backpressure holds output and stalls the FIFO
    reset_dut();
    out_ready = 1'b0;
    push(10, 11); push(20, 21); push(30, 31);
    b = 0;
    while (!out_valid && b < 50) begin
      tick();
      b++;
    end
    chk("t5_valid_rise", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_hold_valid", last_ov, 1);
      chk("t5_hold_data1", out_data1, 10);
      chk("t5_hold_data2", out_data2, 11);
      chk("t5_no_pop", last_rd, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("t5_handshake", last_hs, 1);
    tick();
    chk("t5_next_pop", last_rd, 1);
    drain("t5", 3);
    expect_out("t5_a", 10, 11);
    expect_out("t5_b", 20, 21);
    expect_out("t5_c", 30, 31);

    // 6: coefficient write during MAC is ignored; reset during MAC abandons the sample
    reset_dut();
    push(50, 60);
    wait_pop("t6a");
    repeat (2) tick();
    chk("t6_busy_mac", busy, 1);
    coef_write(0, 0);
    drain("t6a", 1);
    expect_out("t6a", 50, 60);
    coef_write(0, 8192);
    push(70, 80);
    wait_pop("t6b");
    repeat (3) tick();
    #3;
    rst = 1'b0;
    #1;
    chk("t6_rst_data1", out_data1, 0);
    chk("t6_rst_data2", out_data2, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", out_valid, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (12) tick();
    chk("t6_no_emit", oq1.size(), 0);
    push(9, -9);
    drain("t6c", 1);
    expect_out("t6c_identity", 9, -9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
